// File: rtl/math_cabs_cordic.sv
// Pipelined complex magnitude |a + jb| by CORDIC vectoring, one sample per clock.
// Optional gain compensation stage: define MATH_CABS_GAIN_COMP_EN.
module math_cabs_cordic #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 12,
  parameter int GUARD  = 2,
  parameter int TAG_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    din_valid,
  input  logic signed [WIDTH-1:0] dina,
  input  logic signed [WIDTH-1:0] dinb,
  input  logic [TAG_W-1:0]        din_tag,
  output logic                    dout_valid,
  output logic [WIDTH:0]          dout,
  output logic [TAG_W-1:0]        dout_tag
);

  localparam int IW = WIDTH + 2 + GUARD;

  logic signed [IW-1:0] a_ext;
  logic signed [IW-1:0] b_ext;
  assign a_ext = {{2{dina[WIDTH-1]}}, dina, {GUARD{1'b0}}};
  assign b_ext = {{2{dinb[WIDTH-1]}}, dinb, {GUARD{1'b0}}};

  // index 0 is the pre-rotation register, index i+1 holds the result of micro-rotation i
  logic signed [IW-1:0] x_q   [0:STAGES];
  logic signed [IW-1:0] y_q   [0:STAGES-1];
  logic                 v_q   [0:STAGES];
  logic [TAG_W-1:0]     tag_q [0:STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= STAGES; i++) begin
        x_q[i]   <= '0;
        v_q[i]   <= 1'b0;
        tag_q[i] <= '0;
      end
      for (int i = 0; i < STAGES; i++) y_q[i] <= '0;
    end else if (ena) begin
      if (a_ext[IW-1]) begin
        x_q[0] <= -a_ext;
        y_q[0] <= -b_ext;
      end else begin
        x_q[0] <= a_ext;
        y_q[0] <= b_ext;
      end
      v_q[0]   <= din_valid;
      tag_q[0] <= din_tag;
      for (int i = 0; i < STAGES - 1; i++) begin
        if (y_q[i][IW-1]) begin
          x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
        end else begin
          x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
        end
      end
      // the last rotation only needs x; its y result would never be read
      if (y_q[STAGES-1][IW-1])
        x_q[STAGES] <= x_q[STAGES-1] - (y_q[STAGES-1] >>> (STAGES - 1));
      else
        x_q[STAGES] <= x_q[STAGES-1] + (y_q[STAGES-1] >>> (STAGES - 1));
      for (int i = 0; i < STAGES; i++) begin
        v_q[i+1]   <= v_q[i];
        tag_q[i+1] <= tag_q[i];
      end
    end
  end

`ifdef MATH_CABS_GAIN_COMP_EN
  localparam int PW = IW + 17;
  localparam logic [PW-1:0] K_Q17 = PW'(79594);
  localparam logic [PW-1:0] RND   = PW'(1) << (16 + GUARD);

  // multiply by K and round half-up directly at the output LSB, dropping the guard bits
  logic [PW-1:0]    comp_sum;
  logic [WIDTH:0]   cx_q;
  logic             cv_q;
  logic [TAG_W-1:0] ctag_q;
  logic             unused_comp;
  assign comp_sum    = PW'($unsigned(x_q[STAGES])) * K_Q17 + RND;
  assign unused_comp = ^{comp_sum[PW-1], comp_sum[16+GUARD:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cx_q       <= '0;
      cv_q       <= 1'b0;
      ctag_q     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_tag   <= '0;
    end else if (ena) begin
      cx_q       <= comp_sum[17+GUARD +: WIDTH+1];
      cv_q       <= v_q[STAGES];
      ctag_q     <= tag_q[STAGES];
      dout       <= cx_q;
      dout_valid <= cv_q;
      dout_tag   <= ctag_q;
    end
  end
`else
  // x is non-negative after pre-rotation, so its sign bit carries no information
  logic unused_trunc;
  assign unused_trunc = ^{x_q[STAGES][IW-1], x_q[STAGES][GUARD-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_tag   <= '0;
    end else if (ena) begin
      dout       <= x_q[STAGES][GUARD +: WIDTH+1];
      dout_valid <= v_q[STAGES];
      dout_tag   <= tag_q[STAGES];
    end
  end
`endif

endmodule

// File: tb/tb_math_cabs_cordic.sv
// Randomized self-checking bench for math_cabs_cordic against a real-arithmetic magnitude model.
// Expectations follow MATH_CABS_GAIN_COMP_EN when it is defined for the build.
module tb_math_cabs_cordic;
  localparam int WIDTH  = 16;
  localparam int STAGES = 12;
  localparam int GUARD  = 2;
  localparam int TAG_W  = 4;
`ifdef MATH_CABS_GAIN_COMP_EN
  localparam int L = STAGES + 3;
`else
  localparam int L = STAGES + 2;
`endif

  logic                    clk;
  logic                    rst;
  logic                    ena;
  logic                    din_valid;
  logic signed [WIDTH-1:0] dina;
  logic signed [WIDTH-1:0] dinb;
  logic [TAG_W-1:0]        din_tag;
  logic                    dout_valid;
  logic [WIDTH:0]          dout;
  logic [TAG_W-1:0]        dout_tag;

  math_cabs_cordic #(.WIDTH(WIDTH), .STAGES(STAGES), .GUARD(GUARD), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .din_valid(din_valid), .dina(dina), .dinb(dinb),
    .din_tag(din_tag), .dout_valid(dout_valid), .dout(dout), .dout_tag(dout_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int exp;
    int tol;
    int tag;
  } entry_t;

  entry_t hist[$];
  int     n_ena;
  int     checks;
  int     failures;
  real    gain;

  task automatic check_val(input string tag, input longint got, input longint exp,
                           input longint tol = 0);
    checks++;
    if (got > exp + tol || got < exp - tol) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d tol=%0d t=%0t", tag, got, exp, tol, $time);
    end
  endtask

  function automatic entry_t mk(input bit v, input int exp, input int tol, input int tag);
    entry_t e;
    e.v = v; e.exp = exp; e.tol = tol; e.tag = tag;
    return e;
  endfunction

  function automatic entry_t model(input bit v, input int a, input int b, input int tag);
    real m;
    m = $sqrt(real'(a) * real'(a) + real'(b) * real'(b));
`ifdef MATH_CABS_GAIN_COMP_EN
    return mk(v, $rtoi(m + 0.5), 2, tag);
`else
    return mk(v, $rtoi(m * gain), 3, tag);
`endif
  endfunction

  // one clock: drive, clock, then compare against the sample accepted L ena-edges earlier
  task automatic step_e(input bit en, input int a, input int b, input entry_t e);
    int k;
    din_valid = e.v;
    dina      = WIDTH'(a);
    dinb      = WIDTH'(b);
    din_tag   = TAG_W'(e.tag);
    ena       = en;
    @(posedge clk);
    #1;
    if (en) begin
      hist.push_back(e);
      n_ena++;
    end
    k = n_ena - L;
    if (k >= 0 && hist[k].v) begin
      check_val("valid_hi", dout_valid, 1);
      check_val("dout", dout, hist[k].exp, hist[k].tol);
      check_val("tag", dout_tag, hist[k].tag);
    end else begin
      check_val("valid_lo", dout_valid, 0);
    end
  endtask

  task automatic drive(input bit v, input int tag, input bit en);
    int a;
    int b;
    a = int'($urandom_range(0, 65535)) - 32768;
    b = int'($urandom_range(0, 65535)) - 32768;
    step_e(en, a, b, model(v, a, b, tag));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b1);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check_val("rst_valid", dout_valid, 0);
    check_val("rst_dout", dout, 0);
    check_val("rst_tag", dout_tag, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    hist.delete();
    n_ena = 0;
  endtask

  initial begin
    real p;
    checks = 0; failures = 0; n_ena = 0;
    gain = 1.0; p = 1.0;
    for (int i = 0; i < STAGES; i++) begin
      gain = gain * $sqrt(1.0 + p);
      p = p / 4.0;
    end
    rst = 1'b0; ena = 1'b0; din_valid = 1'b0; dina = '0; dinb = '0; din_tag = '0;
    #3;
    check_val("init_valid", dout_valid, 0);
    check_val("init_dout", dout, 0);
    check_val("init_tag", dout_tag, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // directed points
`ifdef MATH_CABS_GAIN_COMP_EN
    step_e(1'b1, 3, 4, mk(1'b1, 5, 1, 5));
    step_e(1'b1, -32768, -32768, mk(1'b1, 46341, 2, 6));
    step_e(1'b1, 0, 0, mk(1'b1, 0, 0, 7));
    step_e(1'b1, -32768, 0, mk(1'b1, 32768, 2, 8));
`else
    step_e(1'b1, 32767, 0, mk(1'b1, 53960, 3, 1));
    step_e(1'b1, 0, -1000, mk(1'b1, 1647, 3, 2));
    step_e(1'b1, 3, 4, model(1'b1, 3, 4, 5));
    step_e(1'b1, -32768, -32768, model(1'b1, -32768, -32768, 6));
`endif
    idle(L + 2);

    // valid pattern 1,0,1,1,0
    drive(1'b1, 1, 1'b1);
    drive(1'b0, 2, 1'b1);
    drive(1'b1, 3, 1'b1);
    drive(1'b1, 4, 1'b1);
    drive(1'b0, 5, 1'b1);
    idle(L + 2);

    // ena low for 7 cycles mid-stream; inputs during the stall must be ignored
    for (int i = 0; i < 6; i++) drive(1'b1, i, 1'b1);
    for (int i = 0; i < 7; i++) drive(1'b1, 15, 1'b0);
    for (int i = 6; i < 12; i++) drive(1'b1, i, 1'b1);
    idle(L + 2);

    // 200 random samples with random stall gaps
    for (int i = 0; i < 200; i++) begin
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      for (int g = 0; g < gap; g++) drive(1'b1, 15 - (i % 16), 1'b0);
      drive(1'b1, i % 16, 1'b1);
    end
    idle(L + 2);

    // reset with five samples in flight: none may emerge afterwards
    for (int i = 0; i < 5; i++) drive(1'b1, 9, 1'b1);
    async_reset();
    drive(1'b1, 12, 1'b1);
    idle(L + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
